dcache_set_assoc_mem: RTL and testbench

DCACHE_SET_ASSOC_MEM -- requirements
Module: dcache_set_assoc_mem

---
 rtl/dcache_set_assoc_mem.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_dcache_set_assoc_mem.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_set_assoc_mem.sv
// Set-associative data cache storage with tree-PLRU replacement, a small
// IDLE/WB/FILL miss FSM and a pool of MSHRs for outstanding block fills.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE with a free MSHR.
// The memory side has no ready wire. A command is held every cycle until
// mem_response is nonzero, which both accepts it and (for loads) carries the
// transaction tag. A fill returns whenever mem_tag is nonzero.
module dcache_set_assoc_mem #(
  parameter  int NUM_SETS = 32,
  parameter  int NUM_WAYS = 4,
  parameter  int TAG_W    = 24,
  parameter  int BLOCK_W  = 64,
  parameter  int NUM_MSHR = 2,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int MS_W     = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_store,
  input  logic [IDX_W-1:0]       req_index,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic [BLOCK_W-1:0]     req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_retry,
  output logic [BLOCK_W-1:0]     rsp_rdata,
  output logic                   mem_cmd_valid,
  output logic                   mem_cmd_is_store,
  output logic [TAG_W+IDX_W-1:0] mem_cmd_addr,
  output logic [BLOCK_W-1:0]     mem_cmd_data,
  input  logic [3:0]             mem_response,
  input  logic [3:0]             mem_tag,
  input  logic [BLOCK_W-1:0]     mem_data,
  output logic                   fill_valid,
  output logic [IDX_W-1:0]       fill_index,
  output logic [TAG_W-1:0]       fill_tag,
  output logic [BLOCK_W-1:0]     fill_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2} state_e;

  typedef struct packed {
    logic               vld;
    logic [3:0]         rtag;
    logic [IDX_W-1:0]   idx;
    logic [WAY_W-1:0]   way;
    logic [TAG_W-1:0]   tag;
    logic               st;
    logic [BLOCK_W-1:0] wdata;
  } mshr_t;

  // PLRU node n has children 2n+1 / 2n+2; a bit of 1 points the victim right.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                    input logic [WAY_W-1:0] way);
    logic [NUM_WAYS-2:0] nb;
    int node;
    nb = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      nb[node] = ~way[WAY_W-1-l];
      node = 2 * node + 1 + int'(way[WAY_W-1-l]);
    end
    return nb;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [WAY_W-1:0] v;
    int node;
    v = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  // Data and tag arrays are plain storage without reset.
  logic [BLOCK_W-1:0] data_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]   tag_q  [NUM_SETS][NUM_WAYS];

  state_e                               state_q, state_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q, valid_d, dirty_q, dirty_d, pending_q, pending_d;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0]    plru_q, plru_d;
  mshr_t [NUM_MSHR-1:0]                 mshr_q, mshr_d;
  logic [IDX_W-1:0]                     r_idx_q, r_idx_d;
  logic [TAG_W-1:0]                     r_tag_q, r_tag_d;
  logic                                 r_st_q, r_st_d;
  logic [BLOCK_W-1:0]                   r_wdata_q, r_wdata_d;
  logic [WAY_W-1:0]                     vict_q, vict_d;
  logic                                 rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic                                 rsp_retry_q, rsp_retry_d;
  logic [BLOCK_W-1:0]                   rsp_rdata_q, rsp_rdata_d;
  logic                                 fill_valid_q, fill_valid_d;
  logic [IDX_W-1:0]                     fill_index_q, fill_index_d;
  logic [TAG_W-1:0]                     fill_tag_q, fill_tag_d;
  logic [BLOCK_W-1:0]                   fill_data_q, fill_data_d;

  logic             lk_hit, lk_pend_match, lk_retry, has_free, skip_found;
  logic [WAY_W-1:0] lk_hit_way, free_way, skip_way, plru_way, cand, lk_victim;
  logic             mshr_free_any, fill_hit;
  logic [MS_W-1:0]  mshr_free_idx, fill_m;
  logic             hit_we, ins_we, tag_we;
  logic [WAY_W-1:0] ins_way;
  logic [IDX_W-1:0] ins_idx;
  logic [BLOCK_W-1:0] ins_data;

  assign req_ready = reset && (state_q == IDLE) && mshr_free_any;

  // Tag lookup, retry detection and victim choice for the presented request.
  always_comb begin
    lk_hit = 1'b0;
    lk_hit_way = '0;
    lk_pend_match = 1'b0;
    has_free = 1'b0;
    free_way = '0;
    skip_found = 1'b0;
    skip_way = '0;
    cand = '0;
    plru_way = plru_victim(plru_q[req_index]);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (tag_q[req_index][w] == req_tag) begin
        if (valid_q[req_index][w] && !lk_hit) begin
          lk_hit = 1'b1;
          lk_hit_way = WAY_W'(w);
        end
        if (pending_q[req_index][w]) lk_pend_match = 1'b1;
      end
      if (!valid_q[req_index][w] && !pending_q[req_index][w] && !has_free) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    for (int k = 0; k < NUM_WAYS; k++) begin
      cand = plru_way + WAY_W'(k);
      if (!skip_found && !pending_q[req_index][cand]) begin
        skip_found = 1'b1;
        skip_way = cand;
      end
    end
    lk_retry = lk_pend_match || (&pending_q[req_index]);
    lk_victim = has_free ? free_way : skip_way;
  end

  // Lowest free MSHR slot, and the MSHR a returning fill belongs to.
  always_comb begin
    mshr_free_any = 1'b0;
    mshr_free_idx = '0;
    fill_hit = 1'b0;
    fill_m = '0;
    for (int m = 0; m < NUM_MSHR; m++) begin
      if (!mshr_q[m].vld && !mshr_free_any) begin
        mshr_free_any = 1'b1;
        mshr_free_idx = MS_W'(m);
      end
      if (mem_tag != 4'd0 && mshr_q[m].vld && mshr_q[m].rtag == mem_tag && !fill_hit) begin
        fill_hit = 1'b1;
        fill_m = MS_W'(m);
      end
    end
  end

  // Miss FSM next state, line status updates, memory commands and fill install.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    pending_d = pending_q;
    plru_d = plru_q;
    mshr_d = mshr_q;
    r_idx_d = r_idx_q;
    r_tag_d = r_tag_q;
    r_st_d = r_st_q;
    r_wdata_d = r_wdata_q;
    vict_d = vict_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d = 1'b0;
    rsp_retry_d = 1'b0;
    rsp_rdata_d = '0;
    fill_valid_d = 1'b0;
    fill_index_d = '0;
    fill_tag_d = '0;
    fill_data_d = '0;
    mem_cmd_valid = 1'b0;
    mem_cmd_is_store = 1'b0;
    mem_cmd_addr = '0;
    mem_cmd_data = '0;
    hit_we = 1'b0;
    ins_we = 1'b0;
    ins_idx = '0;
    ins_way = '0;
    ins_data = '0;
    tag_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          rsp_valid_d = 1'b1;
          if (lk_retry) begin
            rsp_retry_d = 1'b1;
          end else if (lk_hit) begin
            rsp_hit_d = 1'b1;
            plru_d[req_index] = plru_touch(plru_q[req_index], lk_hit_way);
            if (req_is_store) begin
              hit_we = 1'b1;
              dirty_d[req_index][lk_hit_way] = 1'b1;
            end else begin
              rsp_rdata_d = data_q[req_index][lk_hit_way];
            end
          end else begin
            r_idx_d = req_index;
            r_tag_d = req_tag;
            r_st_d = req_is_store;
            r_wdata_d = req_wdata;
            vict_d = lk_victim;
            plru_d[req_index] = plru_touch(plru_q[req_index], lk_victim);
            state_d = (valid_q[req_index][lk_victim] && dirty_q[req_index][lk_victim]) ? WB : FILL;
          end
        end
      end
      WB: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_is_store = 1'b1;
        mem_cmd_addr = {tag_q[r_idx_q][vict_q], r_idx_q};
        mem_cmd_data = data_q[r_idx_q][vict_q];
        if (mem_response != 4'd0) begin
          valid_d[r_idx_q][vict_q] = 1'b0;
          dirty_d[r_idx_q][vict_q] = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr = {r_tag_q, r_idx_q};
        if (mem_response != 4'd0) begin
          mshr_d[mshr_free_idx].vld = 1'b1;
          mshr_d[mshr_free_idx].rtag = mem_response;
          mshr_d[mshr_free_idx].idx = r_idx_q;
          mshr_d[mshr_free_idx].way = vict_q;
          mshr_d[mshr_free_idx].tag = r_tag_q;
          mshr_d[mshr_free_idx].st = r_st_q;
          mshr_d[mshr_free_idx].wdata = r_wdata_q;
          tag_we = 1'b1;
          pending_d[r_idx_q][vict_q] = 1'b1;
          valid_d[r_idx_q][vict_q] = 1'b0;
          dirty_d[r_idx_q][vict_q] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A returning fill targets a pending line, never the hit or victim way.
    if (fill_hit) begin
      ins_we = 1'b1;
      ins_idx = mshr_q[fill_m].idx;
      ins_way = mshr_q[fill_m].way;
      ins_data = mshr_q[fill_m].st ? mshr_q[fill_m].wdata : mem_data;
      valid_d[ins_idx][ins_way] = 1'b1;
      pending_d[ins_idx][ins_way] = 1'b0;
      dirty_d[ins_idx][ins_way] = mshr_q[fill_m].st;
      mshr_d[fill_m].vld = 1'b0;
      fill_valid_d = 1'b1;
      fill_index_d = ins_idx;
      fill_tag_d = mshr_q[fill_m].tag;
      fill_data_d = ins_data;
    end
  end

  // Control state, line status and registered outputs with async reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      pending_q <= '0;
      plru_q <= '0;
      mshr_q <= '0;
      r_idx_q <= '0;
      r_tag_q <= '0;
      r_st_q <= 1'b0;
      r_wdata_q <= '0;
      vict_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_retry_q <= 1'b0;
      rsp_rdata_q <= '0;
      fill_valid_q <= 1'b0;
      fill_index_q <= '0;
      fill_tag_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      pending_q <= pending_d;
      plru_q <= plru_d;
      mshr_q <= mshr_d;
      r_idx_q <= r_idx_d;
      r_tag_q <= r_tag_d;
      r_st_q <= r_st_d;
      r_wdata_q <= r_wdata_d;
      vict_q <= vict_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_retry_q <= rsp_retry_d;
      rsp_rdata_q <= rsp_rdata_d;
      fill_valid_q <= fill_valid_d;
      fill_index_q <= fill_index_d;
      fill_tag_q <= fill_tag_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Array writes: store hit, fill install and tag claim at fill issue.
  always_ff @(posedge clock) begin
    if (hit_we) data_q[req_index][lk_hit_way] <= req_wdata;
    if (ins_we) data_q[ins_idx][ins_way] <= ins_data;
    if (tag_we) tag_q[r_idx_q][vict_q] <= r_tag_q;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_retry = rsp_retry_q;
  assign rsp_rdata = rsp_rdata_q;
  assign fill_valid = fill_valid_q;
  assign fill_index = fill_index_q;
  assign fill_tag = fill_tag_q;
  assign fill_data = fill_data_q;

endmodule

// File: tb/tb_dcache_set_assoc_mem.sv
// Directed bench for dcache_set_assoc_mem: hit/miss, writeback, store fill,
// two outstanding fills, retry on pending lines and reset mid-writeback.
module tb_dcache_set_assoc_mem;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [4:0]  req_index;
  logic [23:0] req_tag;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_hit;
  logic        rsp_retry;
  logic [63:0] rsp_rdata;
  logic        mem_cmd_valid;
  logic        mem_cmd_is_store;
  logic [28:0] mem_cmd_addr;
  logic [63:0] mem_cmd_data;
  logic [3:0]  mem_response;
  logic [3:0]  mem_tag;
  logic [63:0] mem_data;
  logic        fill_valid;
  logic [4:0]  fill_index;
  logic [23:0] fill_tag;
  logic [63:0] fill_data;

  int errors = 0;
  int checks = 0;

  dcache_set_assoc_mem dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_index(req_index), .req_tag(req_tag), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_retry(rsp_retry), .rsp_rdata(rsp_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_is_store(mem_cmd_is_store),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_data(mem_data),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_req(input logic st, input logic [4:0] idx, input logic [23:0] tag,
                          input logic [63:0] wd);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_is_store = st;
    req_index = idx;
    req_tag = tag;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_wdata = '0;
  endtask

  task automatic mem_accept(input logic [3:0] rt);
    mem_response = rt;
    step();
    mem_response = 4'd0;
  endtask

  task automatic mem_fill(input logic [3:0] rt, input logic [63:0] d);
    mem_tag = rt;
    mem_data = d;
    step();
    mem_tag = 4'd0;
    mem_data = '0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_index = '0;
    req_tag = '0;
    req_wdata = '0;
    mem_response = 4'd0;
    mem_tag = 4'd0;
    mem_data = '0;
    repeat (3) step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_mem_cmd", {63'd0, mem_cmd_valid}, 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_fill", {63'd0, fill_valid}, 64'd0);

    // first load miss, fill, then reload hit
    send_req(1'b0, 5'd3, 24'h10, 64'd0);
    chk("m1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("m1_hit", {63'd0, rsp_hit}, 64'd0);
    chk("m1_retry", {63'd0, rsp_retry}, 64'd0);
    chk("m1_cmd_valid", {63'd0, mem_cmd_valid}, 64'd1);
    chk("m1_cmd_store", {63'd0, mem_cmd_is_store}, 64'd0);
    chk("m1_cmd_addr", {35'd0, mem_cmd_addr}, {35'd0, 24'h10, 5'd3});
    mem_accept(4'd5);
    chk("m1_cmd_done", {63'd0, mem_cmd_valid}, 64'd0);
    mem_fill(4'd5, 64'hAA);
    chk("m1_fill_valid", {63'd0, fill_valid}, 64'd1);
    chk("m1_fill_index", {59'd0, fill_index}, 64'd3);
    chk("m1_fill_tag", {40'd0, fill_tag}, 64'h10);
    chk("m1_fill_data", fill_data, 64'hAA);
    chk("m1_line_valid", {63'd0, dut.valid_q[3][0]}, 64'd1);
    chk("m1_line_clean", {63'd0, dut.dirty_q[3][0]}, 64'd0);
    step();
    chk("m1_fill_pulse", {63'd0, fill_valid}, 64'd0);
    send_req(1'b0, 5'd3, 24'h10, 64'd0);
    chk("m1_reload_hit", {63'd0, rsp_hit}, 64'd1);
    chk("m1_reload_data", rsp_rdata, 64'hAA);

    // fill all four ways dirty, then a miss forces a writeback of way 0
    send_req(1'b1, 5'd3, 24'h10, 64'hD0);
    chk("st_hit", {63'd0, rsp_hit}, 64'd1);
    chk("st_hit_rdata", rsp_rdata, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      send_req(1'b1, 5'd3, 24'h10 + 24'(i), 64'hD0 + 64'(i));
      chk("sm_hit", {63'd0, rsp_hit}, 64'd0);
      chk("sm_cmd_store", {63'd0, mem_cmd_is_store}, 64'd0);
      mem_accept(4'(i + 5));
      mem_fill(4'(i + 5), 64'hEE);
      chk("sm_fill_data", fill_data, 64'hD0 + 64'(i));
    end
    send_req(1'b0, 5'd3, 24'h20, 64'd0);
    chk("wb_rsp_hit", {63'd0, rsp_hit}, 64'd0);
    chk("wb_rsp_retry", {63'd0, rsp_retry}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("wb_cmd_valid", {63'd0, mem_cmd_valid}, 64'd1);
      chk("wb_cmd_store", {63'd0, mem_cmd_is_store}, 64'd1);
      chk("wb_cmd_addr", {35'd0, mem_cmd_addr}, {35'd0, 24'h10, 5'd3});
      chk("wb_cmd_data", mem_cmd_data, 64'hD0);
      step();
    end
    mem_accept(4'd1);
    chk("wb_then_load", {63'd0, mem_cmd_is_store}, 64'd0);
    chk("wb_load_addr", {35'd0, mem_cmd_addr}, {35'd0, 24'h20, 5'd3});
    chk("wb_victim_inval", {63'd0, dut.valid_q[3][0]}, 64'd0);
    mem_accept(4'd9);
    mem_fill(4'd9, 64'hBB);
    chk("wb_fill_tag", {40'd0, fill_tag}, 64'h20);
    chk("wb_fill_data", fill_data, 64'hBB);
    send_req(1'b0, 5'd3, 24'h20, 64'd0);
    chk("wb_rehit_data", rsp_rdata, 64'hBB);

    // store miss installs the store data, dirty
    send_req(1'b1, 5'd7, 24'h30, 64'h55);
    chk("smiss_hit", {63'd0, rsp_hit}, 64'd0);
    mem_accept(4'd3);
    mem_fill(4'd3, 64'h11);
    chk("smiss_fill_data", fill_data, 64'h55);
    chk("smiss_fill_index", {59'd0, fill_index}, 64'd7);
    chk("smiss_dirty", {63'd0, dut.dirty_q[7][0]}, 64'd1);
    send_req(1'b0, 5'd7, 24'h30, 64'd0);
    chk("smiss_rehit", rsp_rdata, 64'h55);

    // two outstanding fills returned out of order
    send_req(1'b0, 5'd9, 24'h1, 64'd0);
    mem_accept(4'd3);
    chk("two_ready_one", {63'd0, req_ready}, 64'd1);
    send_req(1'b0, 5'd9, 24'h2, 64'd0);
    mem_accept(4'd4);
    chk("two_ready_full", {63'd0, req_ready}, 64'd0);
    mem_fill(4'd4, 64'h22);
    chk("two_fill2_tag", {40'd0, fill_tag}, 64'h2);
    chk("two_fill2_data", fill_data, 64'h22);
    chk("two_ready_after", {63'd0, req_ready}, 64'd1);
    mem_fill(4'd3, 64'h11);
    chk("two_fill1_tag", {40'd0, fill_tag}, 64'h1);
    chk("two_fill1_data", fill_data, 64'h11);
    mem_fill(4'd7, 64'h99);
    chk("stray_tag_ignored", {63'd0, fill_valid}, 64'd0);
    send_req(1'b0, 5'd9, 24'h1, 64'd0);
    chk("two_hit1", rsp_rdata, 64'h11);
    send_req(1'b0, 5'd9, 24'h2, 64'd0);
    chk("two_hit2", rsp_rdata, 64'h22);

    // retry on a pending line, including a same-cycle fill
    send_req(1'b0, 5'd12, 24'h5, 64'd0);
    mem_accept(4'd2);
    send_req(1'b0, 5'd12, 24'h5, 64'd0);
    chk("pend_retry", {63'd0, rsp_retry}, 64'd1);
    chk("pend_no_hit", {63'd0, rsp_hit}, 64'd0);
    chk("pend_idle", {63'd0, mem_cmd_valid}, 64'd0);
    chk("pend_plru", {61'd0, dut.plru_q[12]}, 64'd3);
    mem_tag = 4'd2;
    mem_data = 64'h77;
    send_req(1'b0, 5'd12, 24'h5, 64'd0);
    mem_tag = 4'd0;
    mem_data = '0;
    chk("same_cyc_retry", {63'd0, rsp_retry}, 64'd1);
    chk("same_cyc_fill", {63'd0, fill_valid}, 64'd1);
    chk("same_cyc_data", fill_data, 64'h77);
    send_req(1'b0, 5'd12, 24'h5, 64'd0);
    chk("pend_later_hit", rsp_rdata, 64'h77);

    // reset asserted during a writeback
    send_req(1'b0, 5'd20, 24'h9, 64'd0);
    mem_accept(4'd9);
    send_req(1'b0, 5'd3, 24'h40, 64'd0);
    chk("rwb_cmd_store", {63'd0, mem_cmd_is_store}, 64'd1);
    chk("rwb_cmd_addr", {35'd0, mem_cmd_addr}, {35'd0, 24'h12, 5'd3});
    chk("rwb_cmd_data", mem_cmd_data, 64'hD2);
    #1 reset = 1'b0;
    #1;
    chk("rwb_cmd_cleared", {63'd0, mem_cmd_valid}, 64'd0);
    chk("rwb_rsp_cleared", {63'd0, rsp_valid}, 64'd0);
    chk("rwb_ready_low", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    step();
    chk("rwb_ready_back", {63'd0, req_ready}, 64'd1);
    mem_fill(4'd9, 64'h99);
    chk("rwb_stale_fill", {63'd0, fill_valid}, 64'd0);
    send_req(1'b0, 5'd20, 24'h9, 64'd0);
    chk("rwb_line_gone", {63'd0, rsp_hit}, 64'd0);
    chk("rwb_no_retry", {63'd0, rsp_retry}, 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
